// File: rtl/seg_scan_counter_pkg.sv
// Shared types and constants for the seg_scan_counter display controller.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_scan_counter_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] dig);
    case (dig)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_counter_in_cond.sv
// Input conditioner: 2-FF synchroniser, stability filter, rising-edge event.
// The accepted level follows the synchronised input after DEB_CYCLES equal samples.
module seg_scan_counter_in_cond #(
  parameter int DEB_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LOAD = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_prev_q;
  logic [CW-1:0] stab_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      stab_q       <= DEB_LOAD;
    end else begin
      sync1_q      <= sig_i;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      // Down-counter restarts whenever the sample agrees with the accepted level.
      if (sync2_q == level_q) begin
        stab_q <= DEB_LOAD;
      end else if (stab_q == '0) begin
        level_q <= sync2_q;
        stab_q  <= DEB_LOAD;
      end else begin
        stab_q <= stab_q - 1'b1;
      end
    end
  end

  assign rise_o = level_q & ~level_prev_q;

endmodule

// File: rtl/seg_scan_counter.sv
// BCD up/down event counter with run/hold control and a multiplexed 7-segment scan.
// Define LEAD_ZERO_BLANK_EN to blank digits above the most significant non-zero digit.
module seg_scan_counter
  import seg_scan_counter_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 4,
  parameter int DEB_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic              counter,
  input  logic              up_dn,
  output logic [DIGITS-1:0] led_en,
  output logic [6:0]        led,
  output logic              running,
  output logic              ovf
);

  localparam int CNT_W = DIGITS * BCD_W;
  localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_TC   = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic btn_evt, cnt_evt;
  logic updn_s1_q, updn_s2_q;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              scan_on_q, scan_on_d;
  logic [DIGITS-1:0] led_en_q, led_en_d;
  logic [6:0]        led_q, led_d;

  logic [CNT_W-1:0]  step_val;
  logic              step_wrap;
  logic [DIGITS-1:0] lead_zero;

  seg_scan_counter_in_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_cond (
    .clk    (clk),
    .rst_n  (rst),
    .sig_i  (button),
    .rise_o (btn_evt)
  );

  seg_scan_counter_in_cond #(.DEB_CYCLES(DEB_CYCLES)) u_cnt_cond (
    .clk    (clk),
    .rst_n  (rst),
    .sig_i  (counter),
    .rise_o (cnt_evt)
  );

  // Carry/borrow ripples through all digits; a carry out of the top digit is the wrap.
  always_comb begin
    logic             carry;
    logic [BCD_W-1:0] dig;
    step_val = count_q;
    carry    = 1'b1;
    dig      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[i*BCD_W +: BCD_W];
      if (carry) begin
        if (updn_s2_q) begin
          if (dig == 4'd9) dig = 4'd0;
          else begin dig = dig + 4'd1; carry = 1'b0; end
        end else begin
          if (dig == 4'd0) dig = 4'd9;
          else begin dig = dig - 4'd1; carry = 1'b0; end
        end
      end
      step_val[i*BCD_W +: BCD_W] = dig;
    end
    step_wrap = carry;
  end

  // Count is applied before the button moves RUN to HOLD.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    case (state_q)
      IDLE: if (btn_evt) begin
        state_d = RUN;
        count_d = '0;
      end
      RUN: begin
        if (cnt_evt) begin
          count_d = step_val;
          ovf_d   = step_wrap;
        end
        if (btn_evt) state_d = HOLD;
      end
      HOLD: if (btn_evt) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

`ifdef LEAD_ZERO_BLANK_EN
  always_comb begin
    logic all_zero;
    lead_zero = '0;
    all_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero && (count_q[i*BCD_W +: BCD_W] == 4'd0);
      lead_zero[i] = all_zero;
    end
    lead_zero[0] = 1'b0;
  end
`else
  assign lead_zero = '0;
`endif

  // First terminal count only enables the scan; later ones advance the digit index.
  always_comb begin
    logic [BCD_W-1:0] cur_dig;
    logic             cur_blank;
    pre_d     = (pre_q == PRE_TC) ? '0 : pre_q + 1'b1;
    idx_d     = idx_q;
    scan_on_d = scan_on_q;
    if (pre_q == PRE_TC) begin
      if (!scan_on_q) scan_on_d = 1'b1;
      else            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    cur_dig   = '0;
    cur_blank = 1'b0;
    led_en_d  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      led_en_d[i] = ~(scan_on_d && (idx_d == IW'(i)));
      if (idx_d == IW'(i)) begin
        cur_dig   = count_q[i*BCD_W +: BCD_W];
        cur_blank = lead_zero[i];
      end
    end
    led_d = (!scan_on_d || cur_blank) ? SEG_BLANK : seg_decode(cur_dig);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      updn_s1_q <= 1'b0;
      updn_s2_q <= 1'b0;
      state_q   <= IDLE;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      pre_q     <= '0;
      idx_q     <= '0;
      scan_on_q <= 1'b0;
      led_en_q  <= '1;
      led_q     <= SEG_BLANK;
    end else begin
      updn_s1_q <= up_dn;
      updn_s2_q <= updn_s1_q;
      state_q   <= state_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      scan_on_q <= scan_on_d;
      led_en_q  <= led_en_d;
      led_q     <= led_d;
    end
  end

  assign led_en  = led_en_q;
  assign led     = led_q;
  assign running = (state_q == RUN);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_seg_scan_counter.sv
// Randomised bench for seg_scan_counter against an integer-valued counter model.
// Under LEAD_ZERO_BLANK_EN the expected display blanks leading zeros.
module tb_seg_scan_counter;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic button = 1'b0, counter = 1'b0, up_dn = 1'b1;
  logic [DIGITS-1:0] led_en;
  logic [6:0] led;
  logic running, ovf;

  logic button2 = 1'b0, counter2 = 1'b0, up_dn2 = 1'b1;
  logic [DIGITS-1:0] led_en2;
  logic [6:0] led2;
  logic running2, ovf2;

  seg_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEB_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .button(button), .counter(counter), .up_dn(up_dn),
    .led_en(led_en), .led(led), .running(running), .ovf(ovf)
  );

  seg_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEB_CYCLES(4)) u_deb (
    .clk(clk), .rst(rst), .button(button2), .counter(counter2), .up_dn(up_dn2),
    .led_en(led_en2), .led(led2), .running(running2), .ovf(ovf2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [6:0] exp_seg(input int value, input int pos);
    int p10 = 1;
    for (int k = 0; k < pos; k++) p10 *= 10;
`ifdef LEAD_ZERO_BLANK_EN
    if (pos > 0 && value < p10) return 7'h7F;
`endif
    return seg_tab[(value / p10) % 10];
  endfunction

  // Reference model: 0 = idle, 1 = run, 2 = hold.
  int m_cnt   = 0;
  int m_state = 0;
  int m_wraps = 0;

  int   ovf_seen = 0, ovf_long = 0, ovf2_seen = 0;
  logic ovf_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (ovf) ovf_seen++;
    if (ovf && ovf_prev) ovf_long++;
    ovf_prev = ovf;
    if (ovf2) ovf2_seen++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One press of button and/or counter; ovf is checked on every cycle of the window.
  task automatic pulse(input bit b, input bit c, input bit dir);
    bit will_wrap;
    will_wrap = c && (m_state == 1) && ((dir && m_cnt == 9999) || (!dir && m_cnt == 0));
    @(negedge clk);
    up_dn = dir; button = b; counter = c;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check("ovf_timing", ovf, (k == 4) && will_wrap);
      if (k == 3) begin
        @(negedge clk);
        button = 1'b0; counter = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    if (c && m_state == 1) m_cnt = dir ? (m_cnt + 1) % 10000 : (m_cnt + 9999) % 10000;
    if (will_wrap) m_wraps++;
    if (b) begin
      case (m_state)
        0: begin m_state = 1; m_cnt = 0; end
        1: m_state = 2;
        default: m_state = 1;
      endcase
    end
    check("running", running, m_state == 1);
  endtask

  task automatic check_disp(input bit which, input int value, input string tag);
    bit seen [DIGITS];
    int idx, nseen;
    logic [DIGITS-1:0] le;
    logic [6:0] l;
    for (int i = 0; i < DIGITS; i++) seen[i] = 1'b0;
    nseen = 0;
    for (int c = 0; c < 2 * DIGITS * SCAN_DIV + 2; c++) begin
      @(posedge clk); #1;
      le = which ? led_en2 : led_en;
      l  = which ? led2 : led;
      check({tag, "_onehot"}, $countones(~le), 1);
      idx = -1;
      for (int i = 0; i < DIGITS; i++) if (~le == (DIGITS'(1) << i)) idx = i;
      if (idx >= 0 && !seen[idx]) begin
        seen[idx] = 1'b1;
        nseen++;
        check($sformatf("%s_d%0d", tag, idx), l, exp_seg(value, idx));
      end
    end
    check({tag, "_all_digits"}, nseen, DIGITS);
  endtask

  task automatic hold2(input bit b, input bit c, input int n);
    @(negedge clk);
    button2 = b; counter2 = c;
    repeat (n) @(negedge clk);
    button2 = 1'b0; counter2 = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led_en", led_en, 4'hF);
    check("rst_led", led, 7'h7F);
    check("rst_running", running, 0);
    check("rst_ovf", ovf, 0);

    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("scan_pre_en", led_en, 4'hF);
    check("scan_pre_led", led, 7'h7F);
    @(posedge clk); #1;
    check("scan_first_en", led_en, 4'hE);
    check("scan_first_led", led, 7'h40);
    @(posedge clk); #1;
    check("scan_hold_en", led_en, 4'hE);
    @(posedge clk); #1;
    check("scan_second_en", led_en, 4'hD);
    check("scan_second_led", led, 7'h40);
    check_disp(0, m_cnt, "idle");

    pulse(1, 0, 1);
    repeat (3) pulse(0, 1, 1);
    check_disp(0, m_cnt, "count3");
    pulse(1, 0, 1);
    repeat (2) pulse(0, 1, 1);
    check_disp(0, m_cnt, "held3");
    pulse(1, 0, 1);
    pulse(0, 1, 1);
    check_disp(0, m_cnt, "resume4");

    repeat (4) pulse(0, 1, 0);
    pulse(0, 1, 0);
    check_disp(0, m_cnt, "wrap_down");
    pulse(0, 1, 1);
    check_disp(0, m_cnt, "wrap_up");

    repeat (42) pulse(0, 1, 1);
    check_disp(0, m_cnt, "val42");
    pulse(1, 1, 1);
    check_disp(0, m_cnt, "simul");

    for (int op = 0; op < 40; op++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      pulse(0, 1, 1'($urandom_range(0, 1)));
      else if (r < 9) pulse(1, 0, 1);
      else            pulse(1, 1, 1'($urandom_range(0, 1)));
      if (op % 8 == 7) check_disp(0, m_cnt, "rand");
    end
    check("ovf_total", ovf_seen, m_wraps);
    check("ovf_width", ovf_long, 0);

    hold2(1, 0, 6);
    check("deb_running", running2, 1);
    up_dn2 = 1'b0;
    hold2(0, 1, 2);
    check("deb_glitch_ovf", ovf2_seen, 0);
    check_disp(1, 0, "deb_glitch");
    hold2(0, 1, 6);
    check("deb_accept_ovf", ovf2_seen, 1);
    check_disp(1, 9999, "deb_accept");

    if (m_state != 1) pulse(1, 0, 1);
    pulse(0, 1, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_led_en", led_en, 4'hF);
    check("mid_rst_led", led, 7'h7F);
    check("mid_rst_running", running, 0);
    check("mid_rst_ovf", ovf, 0);
    m_cnt = 0; m_state = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_en", led_en, 4'hF);
    check_disp(0, m_cnt, "post_rst");
    check("post_rst_running", running, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_counter.md
Name: seg_scan_counter

Overview:
Parametrised successor to the single-width LED display controller. It counts conditioned edges on the `counter` input into a DIGITS-wide BCD value, with up or down direction. A `button`-driven run/hold state machine gates the counting. The value is driven onto a time-multiplexed common-anode 7-segment display. It sits between board push-button/pulse inputs and the display pins.

Parameters:
- DIGITS, 8, number of BCD digits and display enables (1..8).
- SCAN_DIV, 4, clocks per digit scan slot (>=1).
- DEB_CYCLES, 1, synchronised input must be stable this many clocks before it is accepted (>=1; 1 = no filtering).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- button  input  1  run/hold push-button, asynchronous to clk.
- counter  input  1  count pulse, asynchronous to clk.
- up_dn  input  1  1 = count up, 0 = count down; sampled when an edge is accepted.
- led_en  output  DIGITS  digit enables, active-low, one-hot-low while scanning.
- led  output  7  segments {g,f,e,d,c,b,a}, active-low.
- running  output  1  high in RUN state.
- ovf  output  1  one-cycle pulse on wrap (999..9→0 up, 0→999..9 down).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, count=0, digit index=0, prescaler=0.
  - led_en all 1, led=7'h7F (blank), running=0, ovf=0.
  - Deassertion takes effect on the next clk edge.
- Input conditioning (button and counter each):
  - 2-FF synchroniser, then a stability counter.
  - The accepted level updates after DEB_CYCLES consecutive equal samples.
  - A rising edge of the accepted level gives a one-cycle event.
  - Latency from input rise to event: 2+DEB_CYCLES clocks.
- State machine on button events:
  - IDLE→RUN: count cleared to 0.
  - RUN→HOLD: count frozen.
  - HOLD→RUN: count resumes from the held value.
- Counting:
  - Only in RUN. Each counter event adds or subtracts 1 in BCD.
  - Count register updates the clock after the event.
  - Digit carry/borrow ripples within that same cycle.
  - Wrap in either direction asserts ovf for exactly that cycle.
  - Counter events in IDLE or HOLD are discarded.
- Simultaneous button and counter events in RUN: the count is applied first, then the state moves to HOLD; the held value includes that count.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At the terminal value the digit index advances, wrapping DIGITS-1→0.
  - led_en[i]=0 only when index==i.
  - led is the registered decode of the BCD digit at that index; led and led_en change on the same edge.
  - First digit is enabled SCAN_DIV clocks after reset release.
  - In IDLE the display shows the current count (0 after reset).
- Decode for non-BCD nibble values: blank (cannot occur in normal operation).
- Reset mid-count: all state lost immediately; no pending event survives.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined: any digit above the most significant non-zero digit shows led=7'h7F. Digit 0 is always shown. Its led_en still asserts on schedule.
- Not defined: all digits shown, including leading zeros.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, HOLD}.
  - 7-bit active-low segment constants SEG_0..SEG_9 and SEG_BLANK.
  - BCD digit width constant (4).
- One natural sub-module, in_cond (synchroniser + stability filter + rising-edge event). It is instantiated twice, for button and counter.

Test Plan:
- Parameters DIGITS=4, SCAN_DIV=2, DEB_CYCLES=1 unless noted.
- Reset held low, then released → led_en=4'hF and led=7'h7F until the first slot. Then led_en=4'hE, led=SEG_0, then 4'hD with SEG_0, rotating every 2 clocks.
- Button pulse, then 3 counter pulses with up_dn=1 → running=1; count 0003; digit0 slot shows SEG_3. Each increment is visible 4 clocks after its counter rise.
- In RUN, button pulse, then 2 counter pulses → running=0, count stays 0003. Button again, then 1 pulse → count 0004.
- Preload by counting up to 9999, one more pulse up → count 0000, ovf high exactly 1 cycle. With up_dn=0 at 0000 → 9999 and ovf pulse.
- DEB_CYCLES=4: counter glitch high for 2 clocks → no count. Held high for 6 clocks → exactly one count.
- With LEAD_ZERO_BLANK_EN, count 0042 → digits 3,2 show 7'h7F, digit1 shows SEG_4, digit0 shows SEG_2. Also assert rst low mid-scan → outputs return to reset values asynchronously.
